// File: rtl/eq_regif_pkg.sv
// eq_regif_pkg: shared types and constants for the SPI equalizer register interface
// Contents: FSM state enum, command byte bit positions, register bank size defaults.
package eq_regif_pkg;
   typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;
   localparam int RW_BIT       = 7;
   localparam int ADDR_LSB     = 0;
   localparam int NUM_REGS_DEF = 31;
   localparam int ADDR_W_DEF   = 5;
endpackage

// File: rtl/spi_reg_slave_if.sv
// spi_reg_slave_if: register bank port between the SPI slave and the equalizer register bank
// Signals: we (one-cycle write strobe), addr, data_out (write data), rd_data (bank content at addr).
// Modports: master = SPI slave side, slave = register bank side.
interface spi_reg_slave_if
   import eq_regif_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
);
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        data_out;
   logic [7:0]        rd_data;
   modport master (output we, addr, data_out, input rd_data);
   modport slave  (input we, addr, data_out, output rd_data);
endinterface

// File: rtl/spi_reg_slave_sync_edge.sv
// sync_edge: multi-flop synchronizer with registered rise/fall pulse outputs
// Ports: clk, rst (async active-low), d (async input), q (synchronized level),
//        rise/fall (one-cycle pulses on synchronized edges).
module sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);
   logic [STAGES-1:0] ff;
   logic              prev;

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         ff   <= '0;
         prev <= 1'b0;
      end else begin
         ff   <= STAGES'({ff, d});
         prev <= ff[STAGES-1];
      end

   assign q    = ff[STAGES-1];
   assign rise = q & ~prev;
   assign fall = ~q & prev;
endmodule

// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI mode-0 slave turning command/data frames into register bank writes
// Ports: clk, rst (async active-low); sclk/cs_n/mosi SPI inputs, miso SPI output;
//        busy = frame in progress, err = sticky frame error (cleared at next frame start);
//        bus = register bank port (we/addr/data_out driven, rd_data sampled).
// Build option: define SPI_READBACK_EN to shift rd_data out on miso during read frames;
//        otherwise miso stays 0 and read commands flag err.
module spi_reg_slave
   import eq_regif_pkg::*;
#(
   parameter int NUM_REGS    = NUM_REGS_DEF,
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           sclk,
   input  logic           cs_n,
   input  logic           mosi,
   output logic           miso,
   output logic           busy,
   output logic           err,
   spi_reg_slave_if.master bus
);
`ifdef SPI_READBACK_EN
   localparam logic READBACK = 1'b1;
`else
   localparam logic READBACK = 1'b0;
`endif
   state_t                 state;
   logic [2:0]             cnt;
   logic [6:0]             sh;
   logic [7:0]             tx, byte_in;
   logic [ADDR_W-1:0]      cmd_addr, nxt;
   logic [SYNC_STAGES-1:0] mosi_ff;
   logic load, bad, cmd_bad, mosi_s;
   logic cs_q, cs_fall, cs_rise_unused, sclk_rise, sclk_fall, sclk_q_unused;

   sync_edge #(.STAGES(SYNC_STAGES)) u_cs (
      .clk(clk), .rst(rst), .d(cs_n), .q(cs_q), .rise(cs_rise_unused), .fall(cs_fall));
   sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
      .clk(clk), .rst(rst), .d(sclk), .q(sclk_q_unused), .rise(sclk_rise), .fall(sclk_fall));

   assign mosi_s   = mosi_ff[SYNC_STAGES-1];
   assign byte_in  = {sh, mosi_s};
   assign cmd_addr = byte_in[ADDR_LSB +: ADDR_W];
   assign cmd_bad  = 32'(cmd_addr) >= NUM_REGS;
   assign nxt      = (32'(bus.addr) == NUM_REGS - 1) ? '0 : bus.addr + ADDR_W'(1);

   // Write address advances the cycle after the strobe so addr is stable while we=1.
   // Read data is loaded one cycle after addr changes, since rd_data follows addr combinationally.
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         mosi_ff      <= '0;
         state        <= IDLE;
         cnt          <= '0;
         sh           <= '0;
         tx           <= '0;
         load         <= 1'b0;
         bad          <= 1'b0;
         miso         <= 1'b0;
         busy         <= 1'b0;
         err          <= 1'b0;
         bus.we       <= 1'b0;
         bus.addr     <= '0;
         bus.data_out <= '0;
      end else begin
         mosi_ff <= SYNC_STAGES'({mosi_ff, mosi});
         bus.we  <= 1'b0;
         load    <= 1'b0;
         if (bus.we) bus.addr <= nxt;
         if (load) begin
            miso <= READBACK & ~bad & bus.rd_data[7];
            tx   <= {bus.rd_data[6:0], 1'b0};
         end
         if (state == IDLE) begin
            if (cs_fall) begin
               state <= CMD;
               cnt   <= '0;
               err   <= 1'b0;
               bad   <= 1'b0;
               busy  <= 1'b1;
            end
         end else if (cs_q) begin
            // Deselect wins over a coincident 8th edge, so a partial or racing byte is dropped.
            state <= IDLE;
            busy  <= 1'b0;
            miso  <= 1'b0;
         end else begin
            if (sclk_rise) begin
               sh  <= byte_in[6:0];
               cnt <= cnt + 3'd1;
               if (&cnt) begin
                  if (state == CMD) begin
                     bus.addr <= cmd_addr;
                     bad      <= cmd_bad;
                     err      <= cmd_bad | (byte_in[RW_BIT] & ~READBACK);
                     state    <= byte_in[RW_BIT] ? RDATA : WDATA;
                     load     <= byte_in[RW_BIT];
                  end else if (state == WDATA) begin
                     bus.we       <= ~bad;
                     bus.data_out <= byte_in;
                  end else begin
                     bus.addr <= nxt;
                     load     <= 1'b1;
                  end
               end
            end
            // The falling edge right after a byte boundary keeps the freshly loaded MSB.
            if (READBACK && state == RDATA && sclk_fall && cnt != 3'd0) begin
               miso <= tx[7] & ~bad;
               tx   <= {tx[6:0], 1'b0};
            end
         end
      end
endmodule
